gate_stim_seq: RTL and testbench

GATE_STIM_SEQ -- requirements
Module: gate_stim_seq

---
 rtl/gate_stim_seq.sv | 171 +++++++++++++++++
 tb/tb_gate_stim_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gate_stim_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gate_stim_seq
//  Purpose  : Sweeps the four 2-bit input combinations (00,10,01,11 as
//             in1,in2) into a downstream gate block after a settle delay,
//             holding each vector HOLD_CYCLES cycles, for PASSES sweeps.
//  Ports    : clk, rst (sync, active-high)
//             start     - run request, honoured only when idle
//             pause     - freezes sequencing while driving vectors
//             in1/in2   - stimulus bits (in1 = vec_idx[0], in2 = vec_idx[1])
//             vec_valid - strobe on the first cycle of each new vector
//             vec_idx   - index of the vector on in1/in2
//             pass_cnt  - completed sweeps in the current/last run
//             busy      - high while settling or driving
//             done      - one-cycle run-complete pulse
//  Revision : 1.0 - initial release
// ============================================================================
module gate_stim_seq #(
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic       in1,
  output logic       in2,
  output logic       vec_valid,
  output logic [1:0] vec_idx,
  output logic [7:0] pass_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DRIVE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_hold        = 8'(HOLD_CYCLES);
  localparam logic [7:0] c_passes      = 8'(PASSES);

  state_t     state_q, state_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;   // cycles the current vector has been shown
  logic [1:0] idx_q, idx_d;
  logic       shown_q, shown_d;         // a vector is currently presented
  logic [7:0] pass_q, pass_d;
  logic       vld_q, vld_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       in1_q, in2_q;

  // The first DRIVE cycle presents nothing yet: outputs are registered, so
  // the vector decided at the end of that cycle appears one cycle later.
  // This is also why a pause sampled there delays vector 0.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    idx_d        = idx_q;
    shown_d      = shown_q;
    pass_d       = pass_q;
    vld_d        = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d       = 8'd0;
          idx_d        = 2'd0;
          shown_d      = 1'b0;
          hold_cnt_d   = 8'd0;
          settle_cnt_d = 8'd0;
          busy_d       = 1'b1;
          state_d      = (SETTLE_CYCLES == 0) ? S_DRIVE : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_cnt_q == c_settle_last) begin
          state_d = S_DRIVE;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end

      S_DRIVE: begin
        // A paused edge changes nothing, so a pending strobe simply waits.
        if (!pause) begin
          if (!shown_q) begin
            shown_d    = 1'b1;
            idx_d      = 2'd0;
            hold_cnt_d = 8'd1;
            vld_d      = 1'b1;
          end else if (hold_cnt_q != c_hold) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end else if (idx_q != 2'd3) begin
            idx_d      = idx_q + 2'd1;
            hold_cnt_d = 8'd1;
            vld_d      = 1'b1;
          end else if ((pass_q + 8'd1) < c_passes) begin
            pass_d     = pass_q + 8'd1;
            idx_d      = 2'd0;
            hold_cnt_d = 8'd1;
            vld_d      = 1'b1;
          end else begin
            pass_d  = pass_q + 8'd1;
            idx_d   = 2'd0;
            shown_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 8'd0;
      hold_cnt_q   <= 8'd0;
      idx_q        <= 2'd0;
      shown_q      <= 1'b0;
      pass_q       <= 8'd0;
      vld_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      in1_q        <= 1'b0;
      in2_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      idx_q        <= idx_d;
      shown_q      <= shown_d;
      pass_q       <= pass_d;
      vld_q        <= vld_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      in1_q        <= shown_d & idx_d[0];
      in2_q        <= shown_d & idx_d[1];
    end
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign vec_valid = vld_q;
  assign vec_idx   = idx_q;
  assign pass_cnt  = pass_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_stim_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gate_stim_seq
//  Purpose  : Self-checking bench for gate_stim_seq. Two instances: default
//             parameters, and SETTLE=0/HOLD=3/PASSES=2. Expected outputs come
//             from a progress-count model of the run timeline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_stim_seq;

  localparam int A_S = 20, A_H = 1, A_P = 1;
  localparam int B_S = 0,  B_H = 3, B_P = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, pause_a, start_b, pause_b;
  logic       a_in1, a_in2, a_vld, a_busy, a_done;
  logic [1:0] a_idx;
  logic [7:0] a_pass;
  logic       b_in1, b_in2, b_vld, b_busy, b_done;
  logic [1:0] b_idx;
  logic [7:0] b_pass;

  gate_stim_seq u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pause(pause_a),
    .in1(a_in1), .in2(a_in2), .vec_valid(a_vld), .vec_idx(a_idx),
    .pass_cnt(a_pass), .busy(a_busy), .done(a_done)
  );

  gate_stim_seq #(
    .SETTLE_CYCLES(B_S), .HOLD_CYCLES(B_H), .PASSES(B_P)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause_b),
    .in1(b_in1), .in2(b_in2), .vec_valid(b_vld), .vec_idx(b_idx),
    .pass_cnt(b_pass), .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h (done,busy,pass[7:0],idx[1:0],vld,in2,in1)",
                  tag, got, exp);
  endtask

  // Packed output word: {done, busy, pass_cnt, vec_idx, vec_valid, in2, in1}
  function automatic logic [31:0] pack(input bit d, input bit b, input int pc,
                                       input int idx, input bit v);
    logic [1:0] ix;
    logic [7:0] p8;
    ix = idx[1:0];
    p8 = pc[7:0];
    return {17'd0, d, b, p8, ix, v, ix[1], ix[0]};
  endfunction

  function automatic logic [31:0] obs(input bit sel);
    if (sel) return {17'd0, b_done, b_busy, b_pass, b_idx, b_vld, b_in2, b_in1};
    return {17'd0, a_done, a_busy, a_pass, a_idx, a_vld, a_in2, a_in1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input bit st, input bit pz);
    if (sel) begin start_b = st; pause_b = pz; end
    else     begin start_a = st; pause_a = pz; end
  endtask

  // One run. Cycle n is the cycle after the n-th edge following the start
  // edge. prog counts unpaused edges taken in DRIVE (DRIVE begins at cycle s):
  // prog 0 = nothing shown, 1..4HP = display slot prog-1, 4HP+1 = done.
  // mode: 0 no pause, 1 random pause/start everywhere, 2 pause in [plo,phi],
  //       3 pause toggling during settle plus repeated start pulses.
  task automatic run(input bit sel, input int s, input int h, input int p,
                     input int mode, input int pct, input int plo, input int phi,
                     input int abort_at, input string tag);
    int prog, prog_prev, total, n, j;
    bit pz, st, fin;
    logic [31:0] e;
    total = 4 * h * p;
    drive(sel, 1'b1, 1'b0);
    step();
    prog = 0; prog_prev = 0; n = 0; fin = 0;
    while (!fin) begin
      if (prog == 0) begin
        e = pack(0, 1, 0, 0, 0);
      end else if (prog <= total) begin
        j = prog - 1;
        e = pack(0, 1, j / (4 * h), (j / h) % 4, (prog != prog_prev) && (j % h == 0));
      end else begin
        e = pack(1, 0, p, 0, 0);
      end
      check(tag, obs(sel), e);
      if (prog > total) begin
        fin = 1;
      end else if (n == abort_at) begin
        rst = 1'b1;
        drive(sel, 1'b0, 1'b0);
        step();
        check({tag, "_after_rst"}, obs(sel), pack(0, 0, 0, 0, 0));
        rst = 1'b0;
        return;
      end else begin
        case (mode)
          1:       pz = ($urandom_range(0, 99) < pct);
          2:       pz = (n >= plo) && (n <= phi);
          3:       pz = (n < s) ? n[0] : 1'b0;
          default: pz = 1'b0;
        endcase
        st = (mode == 1 || mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
        drive(sel, st, pz);
        step();
        prog_prev = prog;
        if (n >= s && !pz) prog++;
        n++;
        if (n > 4000) begin
          check({tag, "_timeout"}, 32'd1, 32'd0);
          fin = 1;
        end
      end
    end
    // First idle cycle: outputs quiet, pass_cnt keeps its final value.
    drive(sel, 1'b0, 1'($urandom_range(0, 1)));
    step();
    check({tag, "_idle"}, obs(sel), pack(0, 0, p, 0, 0));
    drive(sel, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; pause_a = 1'b0;
    start_b = 1'b0; pause_b = 1'b0;
    repeat (3) step();
    check("reset_a", obs(0), pack(0, 0, 0, 0, 0));
    check("reset_b", obs(1), pack(0, 0, 0, 0, 0));
    rst = 1'b0;

    // Start in the first cycle after reset release.
    run(0, A_S, A_H, A_P, 0, 0, 0, 0, -1, "a_basic");
    run(1, B_S, B_H, B_P, 0, 0, 0, 0, -1, "b_basic");
    // Pause for 5 cycles while vector 2 is shown (first shown at cycle S+3).
    run(0, A_S, A_H, A_P, 2, 0, A_S + 3, A_S + 7, -1, "a_pause_v2");
    // Start re-pulsed while busy, pause toggled in settle: nominal timing.
    run(0, A_S, A_H, A_P, 3, 0, 0, 0, -1, "a_settle_noise");
    run(1, B_S, B_H, B_P, 2, 0, 4, 6, -1, "b_pause_mid");
    // Reset while vector 1 is shown, then a fresh run.
    run(0, A_S, A_H, A_P, 0, 0, 0, 0, A_S + 2, "a_abort");
    run(0, A_S, A_H, A_P, 0, 0, 0, 0, -1, "a_replay");
    run(1, B_S, B_H, B_P, 0, 0, 0, 0, 7, "b_abort");

    // rst and start at the same edge: reset wins, block stays idle.
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    step();
    check("rst_start_a", obs(0), pack(0, 0, 0, 0, 0));
    check("rst_start_b", obs(1), pack(0, 0, 0, 0, 0));
    rst = 1'b0; start_b = 1'b0;
    run(0, A_S, A_H, A_P, 0, 0, 0, 0, -1, "a_post_rst");

    for (int r = 0; r < 10; r++) begin
      run(0, A_S, A_H, A_P, 1, int'($urandom_range(0, 50)), 0, 0, -1, "a_rand");
      run(1, B_S, B_H, B_P, 1, int'($urandom_range(0, 50)), 0, 0, -1, "b_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
